// File: rtl/demux_1_to_n_pkg.sv
// Shared types and constants for the serial-to-parallel demultiplexer.
package demux_1_to_n_pkg;

  typedef enum logic {
    FILL = 1'b0,
    HOLD = 1'b1
  } state_e;

  localparam logic AUTO = 1'b0;
  localparam logic ADDR = 1'b1;

endpackage : demux_1_to_n_pkg

// File: rtl/dec_1_to_n.sv
// Binary slot index plus enable to one-hot write strobe.
module dec_1_to_n #(
  parameter int N = 8,
  parameter int M = $clog2(N)
) (
  input  logic [M-1:0] idx_i,
  input  logic         en_i,
  output logic [N-1:0] strobe_o
);

  // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    strobe_o = '0;
    if (en_i) strobe_o[idx_i] = 1'b1;
  end

endmodule : dec_1_to_n

// File: rtl/demux_1_to_n.sv
// Assembles serial bits into an N-bit word, either in arrival order (auto) or
// by explicit slot select (addressed), and presents it with a valid/ready handshake.
module demux_1_to_n
  import demux_1_to_n_pkg::*;
#(
  parameter int N = 8,
  parameter int M = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inp,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic         addr_mode,
  input  logic [M-1:0] select,
  input  logic         flush,
  output logic [N-1:0] out,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam logic [M-1:0] LAST_SLOT = M'(N - 1);

  state_e       state_q, state_d;
  logic [M-1:0] cnt_q, cnt_d;
  logic [N-1:0] mask_q, mask_d;
  logic [N-1:0] out_q, out_d;
  logic         started_q, started_d;
  logic         mode_q, mode_d;

  logic         eff_mode;
  logic         wr_en;
  logic [M-1:0] slot;
  logic [N-1:0] strobe;
  logic [N-1:0] mask_set;

  assign in_ready  = (state_q == FILL);
  assign out_valid = (state_q == HOLD);
  assign out       = out_q;

  // The mode sampled on the first accept of a word governs the rest of it.
  assign eff_mode = started_q ? mode_q : addr_mode;
  assign wr_en    = in_valid & in_ready & ~flush;
  assign slot     = (eff_mode == ADDR) ? select : cnt_q;
  assign mask_set = mask_q | strobe;

  dec_1_to_n #(.N(N), .M(M)) u_dec (
    .idx_i    (slot),
    .en_i     (wr_en),
    .strobe_o (strobe)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    mask_d    = mask_q;
    out_d     = out_q;
    started_d = started_q;
    mode_d    = mode_q;
    unique case (state_q)
      FILL: begin
        if (flush) begin
          cnt_d     = '0;
          mask_d    = '0;
          started_d = 1'b0;
        end else if (wr_en) begin
          out_d     = (out_q & ~strobe) | (inp ? strobe : '0);
          started_d = 1'b1;
          mode_d    = eff_mode;
          if (eff_mode == ADDR) begin
            mask_d = mask_set;
            if (&mask_set) state_d = HOLD;
          end else begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_SLOT) state_d = HOLD;
          end
        end
      end
      HOLD: begin
        // Flush is deliberately ignored here: a presented word is never dropped.
        if (out_ready) begin
          state_d   = FILL;
          cnt_d     = '0;
          mask_d    = '0;
          started_d = 1'b0;
        end
      end
      default: state_d = FILL;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FILL;
      cnt_q     <= '0;
      mask_q    <= '0;
      out_q     <= '0;
      started_q <= 1'b0;
      mode_q    <= AUTO;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      mask_q    <= mask_d;
      out_q     <= out_d;
      started_q <= started_d;
      mode_q    <= mode_d;
    end
  end

endmodule : demux_1_to_n
